// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: FSM states, mode encodings and the arctangent table.
// Pure declarations, no latency; no flow control involved.
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  // atan(2^-i) scaled by 2^30 and truncated; 24 entries cover the legal ITER range.
  function automatic logic [31:0] atan_q30(input logic [4:0] i);
    case (i)
      5'd0:    return 32'h3243F6A8;
      5'd1:    return 32'h1DAC6705;
      5'd2:    return 32'h0FADBAFC;
      5'd3:    return 32'h07F56EA6;
      5'd4:    return 32'h03FEAB76;
      5'd5:    return 32'h01FFD55B;
      5'd6:    return 32'h00FFFAAA;
      5'd7:    return 32'h007FFF55;
      5'd8:    return 32'h003FFFEA;
      5'd9:    return 32'h001FFFFD;
      5'd10:   return 32'h000FFFFF;
      5'd11:   return 32'h0007FFFF;
      5'd12:   return 32'h0003FFFF;
      5'd13:   return 32'h0001FFFF;
      5'd14:   return 32'h0000FFFF;
      5'd15:   return 32'h00007FFF;
      5'd16:   return 32'h00003FFF;
      5'd17:   return 32'h00001FFF;
      5'd18:   return 32'h00000FFF;
      5'd19:   return 32'h000007FF;
      5'd20:   return 32'h000003FF;
      5'd21:   return 32'h000001FF;
      5'd22:   return 32'h000000FF;
      5'd23:   return 32'h0000007F;
      default: return 32'h00000000;
    endcase
  endfunction

  // Table entry rounded to nearest at Q2.(width-2).
  function automatic logic [63:0] atan_entry(input logic [4:0] i, input int width);
    logic [63:0] raw;
    int          frac;
    raw  = {32'd0, atan_q30(i)};
    frac = width - 2;
    if (frac < 30)
      return (raw + (64'd1 << (29 - frac))) >> (30 - frac);
    else
      return raw << (frac - 30);
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One combinational CORDIC micro-rotation with arithmetic shifts and wrapping sums.
// Zero latency; no flow control.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int WIDTH = 22
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  input  logic [4:0]       i,
  input  logic             mode,
  output logic [WIDTH-1:0] x_nxt,
  output logic [WIDTH-1:0] y_nxt,
  output logic [WIDTH-1:0] z_nxt
);

  logic [WIDTH-1:0] x_sh;
  logic [WIDTH-1:0] y_sh;
  logic [WIDTH-1:0] atan_val;
  logic             d_pos;

  assign x_sh     = $signed(x) >>> i;
  assign y_sh     = $signed(y) >>> i;
  assign atan_val = WIDTH'(atan_entry(i, WIDTH));

  // Rotation steers z towards zero, vectoring steers y towards zero.
  assign d_pos = (mode == MODE_ROT) ? ~z[WIDTH-1] : y[WIDTH-1];

  always_comb begin
    x_nxt = x;
    y_nxt = y;
    z_nxt = z;
    if (d_pos) begin
      x_nxt = x - y_sh;
      y_nxt = y + x_sh;
      z_nxt = z - atan_val;
    end else begin
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
      z_nxt = z + atan_val;
    end
  end

endmodule

// File: rtl/cordic_engine.sv
// Iterative CORDIC engine: one micro-rotation per cycle, ITER+2 cycles per operation.
// No backpressure: start is only honoured in IDLE; done is a single-cycle pulse.
module cordic_engine
  import cordic_pkg::*;
#(
  parameter int WIDTH = 22,
  parameter int ITER  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] z_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] z_out
);

  localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

  state_t           state;
  state_t           state_nxt;
  logic [4:0]       i_cnt;
  logic             mode_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] z_q;
  logic [WIDTH-1:0] x_nxt;
  logic [WIDTH-1:0] y_nxt;
  logic [WIDTH-1:0] z_nxt;
  logic             last_iter;

  assign last_iter = (i_cnt == LAST_ITER);

  cordic_stage #(.WIDTH(WIDTH)) u_stage (
    .x     (x_q),
    .y     (y_q),
    .z     (z_q),
    .i     (i_cnt),
    .mode  (mode_q),
    .x_nxt (x_nxt),
    .y_nxt (y_nxt),
    .z_nxt (z_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)     state_nxt = ST_RUN;
      ST_RUN:  if (last_iter) state_nxt = ST_DONE;
      ST_DONE:                state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  // Results are published only on the final iteration and held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_cnt  <= '0;
      mode_q <= MODE_ROT;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      x_out  <= '0;
      y_out  <= '0;
      z_out  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            x_q    <= x_in;
            y_q    <= y_in;
            z_q    <= z_in;
            mode_q <= mode;
            i_cnt  <= '0;
          end
        end
        ST_RUN: begin
          x_q   <= x_nxt;
          y_q   <= y_nxt;
          z_q   <= z_nxt;
          i_cnt <= i_cnt + 5'd1;
          if (last_iter) begin
            x_out <= x_nxt;
            y_out <= y_nxt;
            z_out <= z_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_engine.sv
// Self-checking bench for cordic_engine: spec vectors, random operands against a
// real-arithmetic reference, and hand-written start/reset timing sequences.
module tb_cordic_engine;

  localparam int     WIDTH = 22;
  localparam int     ITER  = 16;
  localparam int     PER   = ITER + 2;
  // Nominal values carry residual-angle and shift-truncation error.
  localparam longint TOL   = 64;
  localparam longint MODV  = longint'(1) << WIDTH;
  localparam longint HALFV = longint'(1) << (WIDTH - 1);
  localparam real    SCALE = 2.0 ** (WIDTH - 2);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             mode = 1'b0;
  logic [WIDTH-1:0] x_in = '0;
  logic [WIDTH-1:0] y_in = '0;
  logic [WIDTH-1:0] z_in = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] x_out;
  logic [WIDTH-1:0] y_out;
  logic [WIDTH-1:0] z_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cordic_engine #(.WIDTH(WIDTH), .ITER(ITER)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .x_in  (x_in),
    .y_in  (y_in),
    .z_in  (z_in),
    .busy  (busy),
    .done  (done),
    .x_out (x_out),
    .y_out (y_out),
    .z_out (z_out)
  );

  typedef struct {
    longint x, y, z;
    bit     m;
    longint ex, ey, ez;
  } vec_t;

  function automatic longint wrap(input longint v);
    longint r;
    r = v & (MODV - 1);
    if (r >= HALFV) r = r - MODV;
    return r;
  endfunction

  function automatic longint sx(input logic [WIDTH-1:0] v);
    return longint'($signed(v));
  endfunction

  // Reference: textbook CORDIC on integers, atan from the real math library.
  function automatic void model(input longint xi, input longint yi, input longint zi,
                                input bit m, output longint xo, output longint yo,
                                output longint zo);
    longint x, y, z, xn, yn, zn, at;
    longint d;
    x = xi; y = yi; z = zi;
    for (int i = 0; i < ITER; i++) begin
      if (m) d = (y < 0) ? 1 : -1;
      else   d = (z >= 0) ? 1 : -1;
      at = longint'($atan(1.0 / (2.0 ** i)) * SCALE);
      xn = wrap(x - d * (y >>> i));
      yn = wrap(y + d * (x >>> i));
      zn = wrap(z - d * at);
      x = xn; y = yn; z = zn;
    end
    xo = x; yo = y; zo = z;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_tol(input string name, input longint act, input longint exp);
    longint diff;
    total++;
    diff = act - exp;
    if (diff < 0) diff = -diff;
    if (diff > TOL) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, TOL);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ops(input longint x, input longint y, input longint z, input bit m);
    x_in = x[WIDTH-1:0];
    y_in = y[WIDTH-1:0];
    z_in = z[WIDTH-1:0];
    mode = m;
  endtask

  // Start one operation from IDLE, measure latency, return results.
  task automatic run_op(input string name, input longint x, input longint y,
                        input longint z, input bit m,
                        output longint xo, output longint yo, output longint zo);
    int lat;
    drive_ops(x, y, z, m);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 4 * ITER) begin
      tick();
      lat++;
    end
    chk({name, "_latency"}, lat, ITER + 1);
    xo = sx(x_out);
    yo = sx(y_out);
    zo = sx(z_out);
    tick();
    chk({name, "_done_pulse"}, longint'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   vecs[3];
    longint xo, yo, zo, ex, ey, ez;
    longint ax, ay, az, bx, by, bz;
    int     ndone, nexp;

    vecs[0] = '{x: 636751, y: 0,      z: 823550,   m: 1'b0, ex: 741455,  ey: 741455,   ez: 0};
    vecs[1] = '{x: 636751, y: 0,      z: -1647099, m: 1'b0, ex: 0,       ey: -1048576, ez: 0};
    vecs[2] = '{x: 524288, y: 524288, z: 0,        m: 1'b1, ex: 1220957, ey: 0,        ez: 823550};

    // Reset state
    tick();
    tick();
    chk("reset_busy", longint'(busy), 0);
    chk("reset_done", longint'(done), 0);
    chk("reset_x", sx(x_out), 0);
    chk("reset_y", sx(y_out), 0);
    chk("reset_z", sx(z_out), 0);
    rst_n = 1'b1;

    // Directed vectors: exact against the reference, nominal within tolerance
    for (int k = 0; k < 3; k++) begin
      run_op($sformatf("vec%0d", k), vecs[k].x, vecs[k].y, vecs[k].z, vecs[k].m, xo, yo, zo);
      model(vecs[k].x, vecs[k].y, vecs[k].z, vecs[k].m, ex, ey, ez);
      chk($sformatf("vec%0d_x", k), xo, ex);
      chk($sformatf("vec%0d_y", k), yo, ey);
      chk($sformatf("vec%0d_z", k), zo, ez);
      chk_tol($sformatf("vec%0d_x_nom", k), xo, vecs[k].ex);
      chk_tol($sformatf("vec%0d_y_nom", k), yo, vecs[k].ey);
      chk_tol($sformatf("vec%0d_z_nom", k), zo, vecs[k].ez);
    end

    // Random full-range operands, including wrapping cases
    for (int k = 0; k < 20; k++) begin
      longint rx, ry, rz;
      bit     rm;
      rx = wrap(longint'($urandom));
      ry = wrap(longint'($urandom));
      rz = wrap(longint'($urandom));
      rm = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d", k), rx, ry, rz, rm, xo, yo, zo);
      model(rx, ry, rz, rm, ex, ey, ez);
      chk($sformatf("rand%0d_x", k), xo, ex);
      chk($sformatf("rand%0d_y", k), yo, ey);
      chk($sformatf("rand%0d_z", k), zo, ez);
    end

    // start during RUN and DONE with changed operands is ignored
    ax = 300000; ay = -200000; az = 500000;
    model(ax, ay, az, 1'b0, ex, ey, ez);
    drive_ops(ax, ay, az, 1'b0);
    start = 1'b1;
    ndone = 0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      start = 1'b0;
      if (c == 4 || c == 11) begin
        bx = wrap(longint'($urandom));
        by = wrap(longint'($urandom));
        bz = wrap(longint'($urandom));
        drive_ops(bx, by, bz, 1'b1);
        start = 1'b1;
      end
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          chk("ign_latency", c, ITER + 1);
          chk("ign_x", sx(x_out), ex);
          chk("ign_y", sx(y_out), ey);
          chk("ign_z", sx(z_out), ez);
        end
        start = 1'b1;
      end
    end
    start = 1'b0;
    chk("ign_done_count", ndone, 1);

    // Reset mid-RUN discards the operation; first start after release works
    drive_ops(-400000, 350000, -600000, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("midrst_busy_before", longint'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_x", sx(x_out), 0);
    chk("midrst_y", sx(y_out), 0);
    chk("midrst_z", sx(z_out), 0);
    ndone = 0;
    repeat (3) begin
      tick();
      if (done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    rst_n = 1'b1;
    run_op("post_rst", 200000, 100000, -300000, 1'b1, xo, yo, zo);
    model(200000, 100000, -300000, 1'b1, ex, ey, ez);
    chk("post_rst_x", xo, ex);
    chk("post_rst_y", yo, ey);
    chk("post_rst_z", zo, ez);

    // start held high: back-to-back operations, busy/done cadence
    ax = 450000; ay = 120000; az = -700000;
    model(ax, ay, az, 1'b0, ex, ey, ez);
    drive_ops(ax, ay, az, 1'b0);
    start = 1'b1;
    ndone = 0;
    nexp = 0;
    for (int c = 1; c <= 60; c++) begin
      int p;
      tick();
      p = (c - 1) % PER;
      if (p == ITER) nexp++;
      chk($sformatf("held_busy_c%0d", c), longint'(busy), (p < ITER) ? 1 : 0);
      chk($sformatf("held_done_c%0d", c), longint'(done), (p == ITER) ? 1 : 0);
      if (done) begin
        ndone++;
        chk($sformatf("held_x_c%0d", c), sx(x_out), ex);
        chk($sformatf("held_z_c%0d", c), sx(z_out), ez);
      end
    end
    start = 1'b0;
    chk("held_done_count", ndone, nexp);
    repeat (PER + 1) tick();
    chk("final_idle_busy", longint'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
